// File: rtl/bp_cfg_responder_pkg.sv
// Shared types and address map for the per-tile configuration responder.
package bp_cfg_responder_pkg;

  localparam logic [15:0] cfg_addr_freeze     = 16'h0001;
  localparam logic [15:0] cfg_addr_core_id    = 16'h0002;
  localparam logic [15:0] cfg_addr_icache     = 16'h0004;
  localparam logic [15:0] cfg_addr_dcache     = 16'h0005;
  localparam logic [15:0] cfg_addr_cce_mode   = 16'h0006;
  localparam logic [15:0] cfg_addr_ucode_base = 16'h8000;

  typedef enum logic [1:0] {
    e_lce_mode_uncached = 2'd0,
    e_lce_mode_normal   = 2'd1,
    e_lce_mode_nonspec  = 2'd2
  } bp_lce_mode_e;

  typedef enum logic [2:0] {
    e_sel_none,
    e_sel_freeze,
    e_sel_core_id,
    e_sel_icache,
    e_sel_dcache,
    e_sel_cce,
    e_sel_ucode
  } bp_cfg_sel_e;

  typedef enum logic {
    e_ready,
    e_ucode_wait
  } bp_cfg_state_e;

  typedef struct packed {
    logic         freeze;
    bp_lce_mode_e icache_mode;
    bp_lce_mode_e dcache_mode;
    logic         cce_mode;
  } bp_cfg_s;

endpackage

// File: rtl/bp_cfg_decode.sv
// Combinational core-id match and address decode for one configuration command.
module bp_cfg_decode
  import bp_cfg_responder_pkg::*;
#(
  parameter int unsigned cfg_core_width_p        = 8,
  parameter int unsigned cfg_addr_width_p        = 16,
  parameter int unsigned core_id_p               = 0,
  parameter int unsigned num_cce_instr_ram_els_p = 256
) (
  input  logic                                       cfg_w_i,
  input  logic [cfg_core_width_p-1:0]                cfg_core_i,
  input  logic [cfg_addr_width_p-1:0]                cfg_addr_i,
  output logic                                       match_c,
  output bp_cfg_sel_e                                sel_c,
  output logic [$clog2(num_cce_instr_ram_els_p)-1:0] ucode_idx_c
);

  localparam int unsigned ucode_aw_lp = $clog2(num_cce_instr_ram_els_p);
  localparam logic [cfg_addr_width_p-1:0] ucode_base_lp = cfg_addr_width_p'(cfg_addr_ucode_base);

  logic bcast;
  logic ucode_hit;

  // Broadcast only applies to writes; a broadcast read would collide on the response bus.
  always_comb begin
    bcast       = (cfg_core_i == '1);
    match_c     = (cfg_core_i == cfg_core_width_p'(core_id_p)) | (bcast & cfg_w_i);
    ucode_hit   = (cfg_addr_i[cfg_addr_width_p-1:ucode_aw_lp] == ucode_base_lp[cfg_addr_width_p-1:ucode_aw_lp]);
    ucode_idx_c = cfg_addr_i[ucode_aw_lp-1:0];
    sel_c       = e_sel_none;
    case (cfg_addr_i)
      cfg_addr_width_p'(cfg_addr_freeze):   sel_c = e_sel_freeze;
      cfg_addr_width_p'(cfg_addr_core_id):  sel_c = e_sel_core_id;
      cfg_addr_width_p'(cfg_addr_icache):   sel_c = e_sel_icache;
      cfg_addr_width_p'(cfg_addr_dcache):   sel_c = e_sel_dcache;
      cfg_addr_width_p'(cfg_addr_cce_mode): sel_c = e_sel_cce;
      default:                              sel_c = e_sel_none;
    endcase
    if (ucode_hit) sel_c = e_sel_ucode;
  end

endmodule

// File: rtl/bp_cfg_responder.sv
// Per-tile configuration responder: tile config registers, microcode RAM front, single-entry read response.
module bp_cfg_responder
  import bp_cfg_responder_pkg::*;
#(
  parameter int unsigned cfg_core_width_p        = 8,
  parameter int unsigned cfg_addr_width_p        = 16,
  parameter int unsigned cfg_data_width_p        = 32,
  parameter int unsigned core_id_p               = 0,
  parameter int unsigned num_cce_instr_ram_els_p = 256
) (
  input  logic                                       clk_i,
  input  logic                                       reset_n_i,
  input  logic                                       cfg_v_i,
  output logic                                       cfg_ready_o,
  input  logic                                       cfg_w_i,
  input  logic [cfg_core_width_p-1:0]                cfg_core_i,
  input  logic [cfg_addr_width_p-1:0]                cfg_addr_i,
  input  logic [cfg_data_width_p-1:0]                cfg_data_i,
  output logic                                       resp_v_o,
  output logic [cfg_data_width_p-1:0]                resp_data_o,
  input  logic                                       resp_yumi_i,
  output logic                                       freeze_o,
  output logic [1:0]                                 icache_mode_o,
  output logic [1:0]                                 dcache_mode_o,
  output logic                                       cce_mode_o,
  output logic                                       ucode_v_o,
  output logic                                       ucode_w_o,
  output logic [$clog2(num_cce_instr_ram_els_p)-1:0] ucode_addr_o,
  output logic [cfg_data_width_p-1:0]                ucode_data_o,
  input  logic [cfg_data_width_p-1:0]                ucode_data_i
);

  bp_cfg_state_e               state_q, state_d;
  bp_cfg_s                     cfg_q, cfg_d;
  logic                        resp_v_q, resp_v_d;
  logic [cfg_data_width_p-1:0] resp_data_q, resp_data_d;
  logic [cfg_data_width_p-1:0] rd_data_c;
  logic                        match_c, accept_c, wr_c, rd_c;
  bp_cfg_sel_e                 sel_c;

  bp_cfg_decode #(
    .cfg_core_width_p       (cfg_core_width_p),
    .cfg_addr_width_p       (cfg_addr_width_p),
    .core_id_p              (core_id_p),
    .num_cce_instr_ram_els_p(num_cce_instr_ram_els_p)
  ) u_decode (
    .cfg_w_i    (cfg_w_i),
    .cfg_core_i (cfg_core_i),
    .cfg_addr_i (cfg_addr_i),
    .match_c    (match_c),
    .sel_c      (sel_c),
    .ucode_idx_c(ucode_addr_o)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= e_ready;
      cfg_q       <= '{freeze: 1'b1, icache_mode: e_lce_mode_uncached,
                       dcache_mode: e_lce_mode_uncached, cce_mode: 1'b0};
      resp_v_q    <= 1'b0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      resp_v_q    <= resp_v_d;
      resp_data_q <= resp_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    resp_v_d    = resp_v_q;
    resp_data_d = resp_data_q;
    ucode_v_o   = 1'b0;
    ucode_w_o   = 1'b0;
    rd_data_c   = '0;

    cfg_ready_o = (state_q == e_ready) & ~resp_v_q;
    accept_c    = cfg_v_i & cfg_ready_o;
    wr_c        = accept_c & match_c & cfg_w_i;
    rd_c        = accept_c & match_c & ~cfg_w_i;

    case (sel_c)
      e_sel_freeze:  rd_data_c = cfg_data_width_p'(cfg_q.freeze);
      e_sel_core_id: rd_data_c = cfg_data_width_p'(core_id_p);
      e_sel_icache:  rd_data_c = cfg_data_width_p'(cfg_q.icache_mode);
      e_sel_dcache:  rd_data_c = cfg_data_width_p'(cfg_q.dcache_mode);
      e_sel_cce:     rd_data_c = cfg_data_width_p'(cfg_q.cce_mode);
      default:       rd_data_c = '0;
    endcase

    if (resp_v_q & resp_yumi_i) resp_v_d = 1'b0;

    case (state_q)
      e_ready: begin
        if (wr_c) begin
          case (sel_c)
            e_sel_freeze: cfg_d.freeze      = cfg_data_i[0];
            e_sel_icache: cfg_d.icache_mode = bp_lce_mode_e'(cfg_data_i[1:0]);
            e_sel_dcache: cfg_d.dcache_mode = bp_lce_mode_e'(cfg_data_i[1:0]);
            e_sel_cce:    cfg_d.cce_mode    = cfg_data_i[0];
            e_sel_ucode: begin
              ucode_v_o = 1'b1;
              ucode_w_o = 1'b1;
            end
            default: ;
          endcase
        end
        // Microcode reads take one extra cycle for the synchronous RAM.
        if (rd_c) begin
          if (sel_c == e_sel_ucode) begin
            ucode_v_o = 1'b1;
            state_d   = e_ucode_wait;
          end else begin
            resp_v_d    = 1'b1;
            resp_data_d = rd_data_c;
          end
        end
      end
      e_ucode_wait: begin
        resp_v_d    = 1'b1;
        resp_data_d = ucode_data_i;
        state_d     = e_ready;
      end
      default: state_d = e_ready;
    endcase
  end

  assign ucode_data_o  = cfg_data_i;
  assign resp_v_o      = resp_v_q;
  assign resp_data_o   = resp_data_q;
  assign freeze_o      = cfg_q.freeze;
  assign icache_mode_o = cfg_q.icache_mode;
  assign dcache_mode_o = cfg_q.dcache_mode;
  assign cce_mode_o    = cfg_q.cce_mode;

endmodule

// File: tb/tb_bp_cfg_responder.sv
// Testbench for bp_cfg_responder: directed vector table, reset corner cases, random commands vs. reference model.
module tb_bp_cfg_responder;

  localparam int unsigned CW  = 8;
  localparam int unsigned AW  = 16;
  localparam int unsigned DW  = 32;
  localparam int unsigned ID  = 3;
  localparam int unsigned ELS = 256;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cfg_v = 1'b0, cfg_ready_o, cfg_w = 1'b0;
  logic [CW-1:0] cfg_core = '0;
  logic [AW-1:0] cfg_addr = '0;
  logic [DW-1:0] cfg_data = '0;
  logic          resp_v_o, resp_yumi = 1'b0;
  logic [DW-1:0] resp_data_o;
  logic          freeze_o, cce_mode_o;
  logic [1:0]    icache_mode_o, dcache_mode_o;
  logic          ucode_v_o, ucode_w_o;
  logic [7:0]    ucode_addr_o;
  logic [DW-1:0] ucode_data_o, ucode_data_i;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bp_cfg_responder #(
    .cfg_core_width_p(CW), .cfg_addr_width_p(AW), .cfg_data_width_p(DW),
    .core_id_p(ID), .num_cce_instr_ram_els_p(ELS)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .cfg_v_i(cfg_v), .cfg_ready_o(cfg_ready_o), .cfg_w_i(cfg_w),
    .cfg_core_i(cfg_core), .cfg_addr_i(cfg_addr), .cfg_data_i(cfg_data),
    .resp_v_o(resp_v_o), .resp_data_o(resp_data_o), .resp_yumi_i(resp_yumi),
    .freeze_o(freeze_o), .icache_mode_o(icache_mode_o), .dcache_mode_o(dcache_mode_o),
    .cce_mode_o(cce_mode_o), .ucode_v_o(ucode_v_o), .ucode_w_o(ucode_w_o),
    .ucode_addr_o(ucode_addr_o), .ucode_data_o(ucode_data_o), .ucode_data_i(ucode_data_i)
  );

  // Synchronous microcode RAM attached to the responder
  logic [DW-1:0] ram [ELS] = '{default: '0};
  logic [DW-1:0] ram_rd = '0;
  always @(posedge clk) begin
    if (ucode_v_o) begin
      if (ucode_w_o) ram[ucode_addr_o] <= ucode_data_o;
      else           ram_rd <= ram[ucode_addr_o];
    end
  end
  assign ucode_data_i = ram_rd;

  // Reference model: architectural register values and microcode contents
  logic          m_freeze;
  logic [1:0]    m_ic, m_dc;
  logic          m_cce;
  logic [DW-1:0] m_ucode [ELS] = '{default: '0};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_freeze = 1'b1; m_ic = 2'd0; m_dc = 2'd0; m_cce = 1'b0;
  endtask

  function automatic bit is_match(input bit w, input logic [CW-1:0] core);
    return (core == CW'(ID)) || (w && core == {CW{1'b1}});
  endfunction

  function automatic bit in_ucode(input logic [AW-1:0] a);
    return (32'(a) >= 32'h8000) && (32'(a) < 32'h8000 + ELS);
  endfunction

  // Applies a command to the model; returns expected response (lat 0 = none, 1 = register, 2 = microcode)
  task automatic model_cmd(input bit w, input logic [CW-1:0] core, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data, output int lat, output logic [DW-1:0] rdata);
    lat = 0; rdata = '0;
    if (is_match(w, core)) begin
      if (w) begin
        if (addr == 16'h0001) m_freeze = data[0];
        else if (addr == 16'h0004) m_ic = data[1:0];
        else if (addr == 16'h0005) m_dc = data[1:0];
        else if (addr == 16'h0006) m_cce = data[0];
        else if (in_ucode(addr)) m_ucode[32'(addr) - 32'h8000] = data;
      end else begin
        lat = in_ucode(addr) ? 2 : 1;
        if (in_ucode(addr)) rdata = m_ucode[32'(addr) - 32'h8000];
        else if (addr == 16'h0001) rdata = 32'(m_freeze);
        else if (addr == 16'h0002) rdata = 32'(ID);
        else if (addr == 16'h0004) rdata = 32'(m_ic);
        else if (addr == 16'h0005) rdata = 32'(m_dc);
        else if (addr == 16'h0006) rdata = 32'(m_cce);
      end
    end
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_freeze"}, 32'(freeze_o), 32'(m_freeze));
    chk({tag, "_icache"}, 32'(icache_mode_o), 32'(m_ic));
    chk({tag, "_dcache"}, 32'(dcache_mode_o), 32'(m_dc));
    chk({tag, "_cce"}, 32'(cce_mode_o), 32'(m_cce));
  endtask

  // Issues one command at a negedge and follows it through to an empty response slot.
  task automatic run_cmd(input bit w, input logic [CW-1:0] core, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input int exp_lat, input logic [DW-1:0] exp_rdata,
                         input int yumi_delay);
    int mlat;
    logic [DW-1:0] mdata;
    chk("ready_before_cmd", 32'(cfg_ready_o), 32'd1);
    cfg_v = 1'b1; cfg_w = w; cfg_core = core; cfg_addr = addr; cfg_data = data;
    #1;
    if (is_match(w, core) && in_ucode(addr)) begin
      chk("ucode_v", 32'(ucode_v_o), 32'd1);
      chk("ucode_w", 32'(ucode_w_o), 32'(w));
      chk("ucode_addr", 32'(ucode_addr_o), 32'(addr[7:0]));
      if (w) chk("ucode_wdata", ucode_data_o, data);
    end else begin
      chk("ucode_v_quiet", 32'(ucode_v_o), 32'd0);
    end
    model_cmd(w, core, addr, data, mlat, mdata);
    @(negedge clk);
    cfg_v = 1'b0;
    chk_regs("regs");
    if (exp_lat == 0) begin
      chk("no_resp", 32'(resp_v_o), 32'd0);
      chk("ready_after", 32'(cfg_ready_o), 32'd1);
    end else begin
      if (exp_lat == 2) begin
        chk("ucode_resp_early", 32'(resp_v_o), 32'd0);
        chk("ready_in_wait", 32'(cfg_ready_o), 32'd0);
        chk("ucode_v_in_wait", 32'(ucode_v_o), 32'd0);
        @(negedge clk);
      end
      chk("resp_v", 32'(resp_v_o), 32'd1);
      chk("resp_data", resp_data_o, exp_rdata);
      chk("ready_resp_held", 32'(cfg_ready_o), 32'd0);
      for (int i = 0; i < yumi_delay; i++) begin
        @(negedge clk);
        chk("resp_v_hold", 32'(resp_v_o), 32'd1);
        chk("resp_data_hold", resp_data_o, exp_rdata);
        chk("ready_hold", 32'(cfg_ready_o), 32'd0);
      end
      resp_yumi = 1'b1;
      #1;
      chk("ready_yumi_cycle", 32'(cfg_ready_o), 32'd0);
      @(negedge clk);
      resp_yumi = 1'b0;
      chk("resp_v_after_yumi", 32'(resp_v_o), 32'd0);
      chk("ready_after_yumi", 32'(cfg_ready_o), 32'd1);
    end
  endtask

  typedef struct {
    bit            w;
    logic [CW-1:0] core;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            lat;
    logic [DW-1:0] rdata;
  } vec_t;

  vec_t vecs[$];

  logic [CW-1:0] r_core;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  bit            r_w;
  int            r_lat;
  logic [DW-1:0] r_exp;
  int            junk_lat;
  logic [DW-1:0] junk_data;

  initial begin
    vecs.push_back('{1'b1, 8'd3,   16'h0001, 32'h0,        0, 32'h0});
    vecs.push_back('{1'b0, 8'd3,   16'h0002, 32'h0,        1, 32'h3});
    vecs.push_back('{1'b1, 8'hFF,  16'h0004, 32'h2,        0, 32'h0});
    vecs.push_back('{1'b0, 8'd3,   16'h0004, 32'h0,        1, 32'h2});
    vecs.push_back('{1'b1, 8'd5,   16'h0005, 32'h1,        0, 32'h0});
    vecs.push_back('{1'b0, 8'd3,   16'h0005, 32'h0,        1, 32'h0});
    vecs.push_back('{1'b0, 8'hFF,  16'h0002, 32'h0,        0, 32'h0});
    vecs.push_back('{1'b1, 8'd3,   16'h8007, 32'hA5A5A5A5, 0, 32'h0});
    vecs.push_back('{1'b0, 8'd3,   16'h8007, 32'h0,        2, 32'hA5A5A5A5});
    vecs.push_back('{1'b1, 8'd3,   16'h0006, 32'hFFFFFFFF, 0, 32'h0});
    vecs.push_back('{1'b0, 8'd3,   16'h0006, 32'h0,        1, 32'h1});
    vecs.push_back('{1'b0, 8'd3,   16'h0003, 32'h0,        1, 32'h0});
    vecs.push_back('{1'b1, 8'd3,   16'h0002, 32'h7,        0, 32'h0});
    vecs.push_back('{1'b0, 8'd3,   16'h0002, 32'h0,        1, 32'h3});
    vecs.push_back('{1'b1, 8'd3,   16'h0005, 32'h5,        0, 32'h0});
    vecs.push_back('{1'b0, 8'd3,   16'h0005, 32'h0,        1, 32'h1});
    vecs.push_back('{1'b0, 8'd3,   16'h80FF, 32'h0,        2, 32'h0});
    vecs.push_back('{1'b0, 8'd3,   16'h8100, 32'h0,        1, 32'h0});
    vecs.push_back('{1'b1, 8'd3,   16'h0001, 32'h1,        0, 32'h0});
    vecs.push_back('{1'b0, 8'd3,   16'h0001, 32'h0,        1, 32'h1});
    vecs.push_back('{1'b0, 8'd5,   16'h0001, 32'h0,        0, 32'h0});

    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_resp_v", 32'(resp_v_o), 32'd0);
    chk("rst_freeze", 32'(freeze_o), 32'd1);
    reset_n = 1'b1;
    @(negedge clk);
    chk_regs("post_reset");
    chk("post_reset_resp_v", 32'(resp_v_o), 32'd0);
    chk("post_reset_resp_data", resp_data_o, 32'd0);
    chk("post_reset_ready", 32'(cfg_ready_o), 32'd1);
    chk("post_reset_ucode_v", 32'(ucode_v_o), 32'd0);

    foreach (vecs[i])
      run_cmd(vecs[i].w, vecs[i].core, vecs[i].addr, vecs[i].data, vecs[i].lat, vecs[i].rdata, 0);

    // Response held with yumi low for five cycles
    run_cmd(1'b0, 8'd3, 16'h0002, 32'h0, 1, 32'h3, 5);

    // Reset while the microcode read is outstanding
    cfg_v = 1'b1; cfg_w = 1'b0; cfg_core = 8'd3; cfg_addr = 16'h8007;
    @(negedge clk);
    cfg_v = 1'b0;
    chk("wait_state_ready", 32'(cfg_ready_o), 32'd0);
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("rst_wait_resp_v", 32'(resp_v_o), 32'd0);
    chk("rst_wait_ready", 32'(cfg_ready_o), 32'd1);
    chk_regs("rst_wait");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_wait_no_late_resp", 32'(resp_v_o), 32'd0);
    chk("rst_wait_ready_after", 32'(cfg_ready_o), 32'd1);
    chk("rst_wait_freeze_after", 32'(freeze_o), 32'd1);

    // Reset while a register response is held
    run_cmd(1'b1, 8'd3, 16'h0004, 32'h1, 0, 32'h0, 0);
    cfg_v = 1'b1; cfg_w = 1'b0; cfg_core = 8'd3; cfg_addr = 16'h0004;
    @(negedge clk);
    cfg_v = 1'b0;
    chk("held_resp_v", 32'(resp_v_o), 32'd1);
    chk("held_resp_data", resp_data_o, 32'd1);
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("rst_held_resp_v", 32'(resp_v_o), 32'd0);
    chk("rst_held_resp_data", resp_data_o, 32'd0);
    chk("rst_held_icache", 32'(icache_mode_o), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_held_ready_after", 32'(cfg_ready_o), 32'd1);

    // Random commands against the reference model
    for (int n = 0; n < 400; n++) begin
      r_w = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0, 1:    r_core = CW'(ID);
        2:       r_core = {CW{1'b1}};
        default: r_core = CW'($urandom);
      endcase
      case ($urandom_range(0, 8))
        0:       r_addr = 16'h0001;
        1:       r_addr = 16'h0002;
        2:       r_addr = 16'h0004;
        3:       r_addr = 16'h0005;
        4:       r_addr = 16'h0006;
        5, 6:    r_addr = 16'h8000 + 16'($urandom_range(0, 15));
        7:       r_addr = 16'h8000 + 16'($urandom_range(0, ELS - 1));
        default: r_addr = 16'($urandom);
      endcase
      r_data = $urandom;
      // Peek at the model's answer without committing, then run_cmd applies it for real.
      begin
        logic mf; logic [1:0] mi, md; logic mc; logic [DW-1:0] mu;
        mf = m_freeze; mi = m_ic; md = m_dc; mc = m_cce;
        mu = in_ucode(r_addr) ? m_ucode[32'(r_addr) - 32'h8000] : '0;
        model_cmd(r_w, r_core, r_addr, r_data, r_lat, r_exp);
        m_freeze = mf; m_ic = mi; m_dc = md; m_cce = mc;
        if (in_ucode(r_addr)) m_ucode[32'(r_addr) - 32'h8000] = mu;
      end
      run_cmd(r_w, r_core, r_addr, r_data, r_lat, r_exp, $urandom_range(0, 3));
    end

    // Final readback of every config register
    for (int a = 1; a <= 6; a++) begin
      model_cmd(1'b0, 8'd3, 16'(a), 32'h0, junk_lat, junk_data);
      run_cmd(1'b0, 8'd3, 16'(a), 32'h0, junk_lat, junk_data, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
